flash_test_seq: RTL and testbench
=================================

Name: flash_test_seq

Overview:
- Command sequencer directly upstream of the SPI flash engine. It drives that engine's cmd_type/flash_cmd/flash_addr request interface and consumes its Done_Sig, mydata_o and myvalid_o outputs.
- It runs one full self-test on a start pulse: read ID, write enable, sector erase, busy poll, write enable, page program, busy poll, 256-byte read-back and compare.
- The page-program payload is byte i = i[7:0], so the expected read-back of byte i is i[7:0].
- It reports pass/fail, the error count and the captured ID bytes.

Parameters:
TEST_ADDR, 24'h000000, base address used for sector erase, page program and read.
POLL_MAX, 1000000, maximum status-register reads per busy poll before a timeout.

Ports:
clock25M  in  1  system clock; all logic on the rising edge.
flash_rst  in  1  asynchronous, active-high reset.
start  in  1  one-cycle test request; ignored unless state is IDLE.
Done_Sig  in  1  command-complete strobe from the SPI engine.
mydata_o  in  8  received byte from the SPI engine.
myvalid_o  in  1  one-cycle qualifier for mydata_o.
cmd_type  out  4  bit3 = request; bits[2:0] = operation code.
flash_cmd  out  8  SPI opcode.
flash_addr  out  24  SPI address.
busy  out  1  high whenever state is not IDLE.
test_done  out  1  one-cycle pulse at the end of a test.
test_pass  out  1  sticky result of the last test; cleared by start.
err_cnt  out  9  mismatching or missing read bytes, 0..256.
timeout  out  1  sticky; set when a poll exceeds POLL_MAX.
mfr_id  out  8  ID byte at index 3.
dev_id  out  8  ID byte at index 4.
seq_state  out  4  current state encoding, for debug.

Behaviour:
- Reset (asynchronous, active-high): every output is 0; state = IDLE; all counters cleared.
  - Reset mid-command drops cmd_type[3] immediately. The engine is assumed reset together with this block.
- Operation codes (cmd_type[2:0] / flash_cmd / flash_addr):
  - RDID: 000 / 0x90 / 0.
  - WREN: 001 / 0x06 / 0.
  - SE: 010 / 0x20 / TEST_ADDR.
  - RDSR: 011 / 0x05 / 0.
  - WRDI: 100 / 0x04 / 0.
  - PP: 101 / 0x02 / TEST_ADDR.
  - READ: 110 / 0x03 / TEST_ADDR.
- Issue rule for every command:
  - cmd_type[2:0], flash_cmd and flash_addr are registered one cycle before cmd_type[3] rises.
  - All four fields stay stable while cmd_type[3]=1.
  - cmd_type[3] clears on the rising edge where Done_Sig=1 is sampled.
  - After any Done_Sig, cmd_type[3] stays 0 for at least 2 cycles before the next request.
  - Done_Sig while no request is outstanding is ignored.
- States:
  - IDLE → ID on start.
    - start clears test_pass, timeout, err_cnt, mfr_id and dev_id.
  - ID: issue RDID and count myvalid_o pulses from 0.
    - Capture byte index 3 into mfr_id and index 4 into dev_id.
    - On Done_Sig → WEN1.
  - WEN1: issue WREN; on Done_Sig → ERASE.
  - ERASE: issue SE; on Done_Sig → POLL1.
  - POLL1 / POLL2: issue RDSR repeatedly and latch the byte on myvalid_o.
    - On Done_Sig with latched bit0=0: POLL1 → WEN2, POLL2 → READ.
    - With bit0=1: increment the poll counter and reissue.
    - When the counter reaches POLL_MAX: set timeout, issue WRDI → FIN.
    - The poll counter clears on entry to each poll state.
  - WEN2: issue WREN; on Done_Sig → PROG.
  - PROG: issue PP; on Done_Sig → POLL2.
  - READ: issue READ and keep a 9-bit byte index.
    - Each myvalid_o with index < 256: compare mydata_o to index[7:0]; on mismatch err_cnt += 1.
    - Pulses after index 256 are ignored.
    - On Done_Sig: if index < 256, err_cnt += (256 − index). Then → FIN.
  - FIN (one cycle): test_done=1; test_pass = (err_cnt==0 && !timeout) → IDLE.
- myvalid_o outside the ID, POLL and READ states is ignored. err_cnt saturates at 256.
- Latency: from start to the first cmd_type[3]=1 is exactly 2 cycles.

Test Plan:
- Reset asserted mid-PROG with cmd_type[3]=1 → all outputs 0 on the same edge; seq_state=IDLE.
- Model returns ID bytes 0xFF,0xFF,0xFF,0xEF,0x16; busy clears after 3 polls; read returns bytes 0..255 → mfr_id=0xEF, dev_id=0x16, err_cnt=0, test_pass=1, test_done pulses once.
- Same run, but read byte 17 returns 0x00 and byte 200 returns 0xFF → err_cnt=2, test_pass=0.
- Model's READ asserts Done_Sig after only 250 bytes (all correct) → err_cnt=6, test_pass=0.
- POLL_MAX=4, status bit0 held at 1 → exactly 4 RDSR commands in POLL1, then WRDI; timeout=1, test_pass=0, no PP is ever issued.
- start pulsed while busy, and Done_Sig pulsed while in IDLE → no new sequence starts and no state change occurs; cmd_type[3] never stays high across a Done_Sig edge, with at least 2 low cycles between requests.

Source files
------------

// File: rtl/flash_test_seq.sv
// flash_test_seq: self-test sequencer sitting in front of the SPI flash engine.
// A start pulse runs read-ID, write-enable, sector erase, busy poll,
// write-enable, page program, busy poll and a 256-byte read-back compare
// (byte i must read back as i[7:0]). It reports pass/fail, the error count
// and the two captured ID bytes.
module flash_test_seq #(
    parameter logic [23:0] TEST_ADDR = 24'h000000,
    parameter int unsigned POLL_MAX  = 1000000
) (
    input  logic        clock25M,
    input  logic        flash_rst,
    input  logic        start,
    input  logic        Done_Sig,
    input  logic [7:0]  mydata_o,
    input  logic        myvalid_o,
    output logic [3:0]  cmd_type,
    output logic [7:0]  flash_cmd,
    output logic [23:0] flash_addr,
    output logic        busy,
    output logic        test_done,
    output logic        test_pass,
    output logic [8:0]  err_cnt,
    output logic        timeout,
    output logic [7:0]  mfr_id,
    output logic [7:0]  dev_id,
    output logic [3:0]  seq_state
);

    // Sequencer states; the encoding is visible on seq_state for debug.
    localparam logic [3:0] S_IDLE  = 4'd0;
    localparam logic [3:0] S_ID    = 4'd1;
    localparam logic [3:0] S_WEN1  = 4'd2;
    localparam logic [3:0] S_ERASE = 4'd3;
    localparam logic [3:0] S_POLL1 = 4'd4;
    localparam logic [3:0] S_WEN2  = 4'd5;
    localparam logic [3:0] S_PROG  = 4'd6;
    localparam logic [3:0] S_POLL2 = 4'd7;
    localparam logic [3:0] S_READ  = 4'd8;
    localparam logic [3:0] S_ABORT = 4'd9;
    localparam logic [3:0] S_FIN   = 4'd10;

    // Issue phases of the current command. LOAD registers the command
    // fields, REQ raises the request one cycle later, WAIT holds it until
    // Done_Sig. Going back through LOAD after every Done_Sig gives the
    // two idle request cycles the engine needs between commands.
    localparam logic [1:0] PH_LOAD = 2'd0;
    localparam logic [1:0] PH_REQ  = 2'd1;
    localparam logic [1:0] PH_WAIT = 2'd2;

    localparam int              PW       = $clog2(POLL_MAX + 1);
    localparam logic [PW-1:0]   POLL_LIM = PW'(POLL_MAX);

    logic [3:0]    state;
    logic [1:0]    phase;
    logic [PW-1:0] poll_cnt;
    logic [PW-1:0] poll_cnt_inc;
    logic          status_busy;
    logic [8:0]    byte_idx;

    logic [2:0]    op_code;
    logic [7:0]    op_byte;
    logic [23:0]   op_addr;

    logic          is_poll;
    logic          req_done;
    logic          poll_busy;
    logic          rd_hit;
    logic          rd_bad;
    logic [8:0]    idx_after;
    logic [9:0]    err_sum;
    logic [8:0]    err_next;

    assign busy         = (state != S_IDLE);
    assign seq_state    = state;
    assign is_poll      = (state == S_POLL1) || (state == S_POLL2);
    assign req_done     = cmd_type[3] && Done_Sig;
    assign poll_cnt_inc = poll_cnt + PW'(1);
    // A status byte arriving together with Done_Sig still decides the poll.
    assign poll_busy    = (is_poll && myvalid_o) ? mydata_o[0] : status_busy;

    // Command fields issued from each state.
    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        op_code = 3'b000;
        op_byte = 8'h00;
        op_addr = 24'h000000;
        case (state)
            S_ID:           begin op_code = 3'b000; op_byte = 8'h90; end
            S_WEN1, S_WEN2: begin op_code = 3'b001; op_byte = 8'h06; end
            S_ERASE:        begin op_code = 3'b010; op_byte = 8'h20; op_addr = TEST_ADDR; end
            S_POLL1,
            S_POLL2:        begin op_code = 3'b011; op_byte = 8'h05; end
            S_ABORT:        begin op_code = 3'b100; op_byte = 8'h04; end
            S_PROG:         begin op_code = 3'b101; op_byte = 8'h02; op_addr = TEST_ADDR; end
            S_READ:         begin op_code = 3'b110; op_byte = 8'h03; op_addr = TEST_ADDR; end
            default:        ;
        endcase
    end

    // Read-back compare: count mismatches, and on completion charge every
    // byte that never arrived. The total saturates at 256.
    always_comb begin
        rd_hit    = (state == S_READ) && myvalid_o && !byte_idx[8];
        rd_bad    = rd_hit && (mydata_o != byte_idx[7:0]);
        idx_after = byte_idx + {8'd0, rd_hit};
        err_sum   = {1'b0, err_cnt} + {9'd0, rd_bad};
        if ((state == S_READ) && req_done)
            err_sum = err_sum + (10'd256 - {1'b0, idx_after});
        err_next  = (err_sum > 10'd256) ? 9'd256 : err_sum[8:0];
    end

    // Main sequencer: state, command issue handshake, poll counting.
    always_ff @(posedge clock25M or posedge flash_rst) begin
        // NOTE: non-blocking throughout so every register sees pre-edge values.
        if (flash_rst) begin
            state      <= S_IDLE;
            phase      <= PH_LOAD;
            cmd_type   <= 4'd0;
            flash_cmd  <= 8'h00;
            flash_addr <= 24'h000000;
            poll_cnt   <= '0;
            timeout    <= 1'b0;
        end else if (state == S_IDLE) begin
            phase <= PH_LOAD;
            if (start) begin
                // RDID fields go out with the state change so the request
                // rises two cycles after start.
                state      <= S_ID;
                phase      <= PH_REQ;
                cmd_type   <= 4'b0000;
                flash_cmd  <= 8'h90;
                flash_addr <= 24'h000000;
                timeout    <= 1'b0;
            end
        end else if (state == S_FIN) begin
            state <= S_IDLE;
            phase <= PH_LOAD;
        end else begin
            case (phase)
                PH_LOAD: begin
                    cmd_type   <= {1'b0, op_code};
                    flash_cmd  <= op_byte;
                    flash_addr <= op_addr;
                    phase      <= PH_REQ;
                end
                PH_REQ: begin
                    cmd_type[3] <= 1'b1;
                    phase       <= PH_WAIT;
                end
                default: begin
                    if (req_done) begin
                        cmd_type[3] <= 1'b0;
                        phase       <= PH_LOAD;
                        case (state)
                            S_ID:    state <= S_WEN1;
                            S_WEN1:  state <= S_ERASE;
                            S_ERASE: begin state <= S_POLL1; poll_cnt <= '0; end
                            S_WEN2:  state <= S_PROG;
                            S_PROG:  begin state <= S_POLL2; poll_cnt <= '0; end
                            S_POLL1, S_POLL2: begin
                                if (!poll_busy) begin
                                    state <= (state == S_POLL1) ? S_WEN2 : S_READ;
                                end else if (poll_cnt_inc == POLL_LIM) begin
                                    timeout <= 1'b1;
                                    state   <= S_ABORT;
                                end else begin
                                    poll_cnt <= poll_cnt_inc;
                                end
                            end
                            S_READ:  state <= S_FIN;
                            S_ABORT: state <= S_FIN;
                            default: state <= S_IDLE;
                        endcase
                    end
                end
            endcase
        end
    end

    // Received-byte datapath: ID capture, status latch, compare and results.
    always_ff @(posedge clock25M or posedge flash_rst) begin
        if (flash_rst) begin
            byte_idx    <= 9'd0;
            status_busy <= 1'b0;
            mfr_id      <= 8'h00;
            dev_id      <= 8'h00;
            err_cnt     <= 9'd0;
            test_pass   <= 1'b0;
            test_done   <= 1'b0;
        end else begin
            test_done <= (state == S_FIN);
            if (state == S_FIN)
                test_pass <= (err_cnt == 9'd0) && !timeout;

            if ((state == S_IDLE) && start) begin
                mfr_id    <= 8'h00;
                dev_id    <= 8'h00;
                err_cnt   <= 9'd0;
                test_pass <= 1'b0;
            end

            // The byte index only lives inside ID and READ; it restarts
            // from zero on entry to either.
            if ((state != S_ID) && (state != S_READ))
                byte_idx <= 9'd0;
            else if (myvalid_o && !byte_idx[8])
                byte_idx <= byte_idx + 9'd1;

            if ((state == S_ID) && myvalid_o) begin
                if (byte_idx == 9'd3) mfr_id <= mydata_o;
                if (byte_idx == 9'd4) dev_id <= mydata_o;
            end

            if (is_poll && myvalid_o)
                status_busy <= mydata_o[0];

            if (state == S_READ)
                err_cnt <= err_next;
        end
    end

endmodule

// File: tb/tb_flash_test_seq.sv
// tb_flash_test_seq: drives flash_test_seq with a behavioural SPI-engine
// model and compares the issued command stream and final results against a
// scenario-level model of the self-test.
`timescale 1ns/1ps
module tb_flash_test_seq;

    localparam logic [23:0] TB_ADDR     = 24'h012300;
    localparam int          TB_POLL_MAX = 4;
    localparam int          STUCK       = 1000;

    logic        clock25M  = 1'b0;
    logic        flash_rst = 1'b0;
    logic        start     = 1'b0;
    logic        Done_Sig  = 1'b0;
    logic [7:0]  mydata_o  = 8'h00;
    logic        myvalid_o = 1'b0;
    logic [3:0]  cmd_type;
    logic [7:0]  flash_cmd;
    logic [23:0] flash_addr;
    logic        busy;
    logic        test_done;
    logic        test_pass;
    logic [8:0]  err_cnt;
    logic        timeout;
    logic [7:0]  mfr_id;
    logic [7:0]  dev_id;
    logic [3:0]  seq_state;

    always #20 clock25M = ~clock25M;

    flash_test_seq #(.TEST_ADDR(TB_ADDR), .POLL_MAX(TB_POLL_MAX)) dut (
        .clock25M   (clock25M),
        .flash_rst  (flash_rst),
        .start      (start),
        .Done_Sig   (Done_Sig),
        .mydata_o   (mydata_o),
        .myvalid_o  (myvalid_o),
        .cmd_type   (cmd_type),
        .flash_cmd  (flash_cmd),
        .flash_addr (flash_addr),
        .busy       (busy),
        .test_done  (test_done),
        .test_pass  (test_pass),
        .err_cnt    (err_cnt),
        .timeout    (timeout),
        .mfr_id     (mfr_id),
        .dev_id     (dev_id),
        .seq_state  (seq_state)
    );

    int total = 0;
    int bad   = 0;

    // Scenario description consumed by the engine model and reference model.
    logic [7:0]  id_q [5];
    int          busy_n [2];
    int          rd_len;
    logic [7:0]  rd_data [300];
    bit          reset_in_pp;
    bit          start_while_busy;

    // Engine-model bookkeeping.
    int          poll_phase;
    int          poll_idx;
    logic [35:0] cap_fields;
    int          stable_err;

    task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] exp_code(input logic [7:0] op);
        case (op)
            8'h90:   return 3'd0;
            8'h06:   return 3'd1;
            8'h20:   return 3'd2;
            8'h05:   return 3'd3;
            8'h04:   return 3'd4;
            8'h02:   return 3'd5;
            8'h03:   return 3'd6;
            default: return 3'd7;
        endcase
    endfunction

    function automatic logic [23:0] exp_addr(input logic [7:0] op);
        return (op == 8'h20 || op == 8'h02 || op == 8'h03) ? TB_ADDR : 24'h000000;
    endfunction

    // One cycle with a request outstanding; the request fields must hold.
    task automatic tick();
        @(negedge clock25M);
        if ({cmd_type, flash_cmd, flash_addr} !== cap_fields) stable_err++;
    endtask

    task automatic set_defaults();
        id_q             = '{8'hFF, 8'hFF, 8'hFF, 8'hEF, 8'h16};
        busy_n           = '{3, 3};
        rd_len           = 256;
        reset_in_pp      = 1'b0;
        start_while_busy = 1'b0;
        for (int i = 0; i < 300; i++) rd_data[i] = 8'(i);
    endtask

    task automatic randomize_scenario();
        int p;
        set_defaults();
        foreach (id_q[i]) id_q[i] = 8'($urandom);
        busy_n[0] = $urandom_range(0, 3);
        busy_n[1] = $urandom_range(0, 3);
        if ($urandom_range(0, 4) == 0) busy_n[$urandom_range(0, 1)] = STUCK;
        case ($urandom_range(0, 2))
            0:       rd_len = 256;
            1:       rd_len = $urandom_range(257, 262);
            default: rd_len = $urandom_range(200, 255);
        endcase
        repeat ($urandom_range(0, 3)) begin
            p = $urandom_range(0, 299);
            rd_data[p] = rd_data[p] ^ 8'($urandom_range(1, 255));
        end
    endtask

    // Behavioural SPI engine: answer one request with its bytes, then Done_Sig.
    task automatic serve_cmd(input string tag, input logic [7:0] op);
        logic [7:0] resp[$];
        logic [7:0] r;
        cap_fields = {cmd_type, flash_cmd, flash_addr};
        stable_err = 0;
        case (op)
            8'h90: foreach (id_q[i]) resp.push_back(id_q[i]);
            8'h05: begin
                r    = 8'($urandom);
                r[0] = (poll_idx < busy_n[poll_phase]);
                poll_idx++;
                resp.push_back(r);
            end
            8'h03: for (int i = 0; i < rd_len; i++) resp.push_back(rd_data[i]);
            default: begin
                if (op == 8'h20) poll_phase = 0;
                if (op == 8'h02) poll_phase = 1;
                poll_idx = 0;
            end
        endcase
        if (start_while_busy && op == 8'h20) begin
            start = 1'b1;
            tick();
            start = 1'b0;
            check({tag, " start_ignored"}, {busy, cmd_type[3], flash_cmd}, {1'b1, 1'b1, 8'h20});
        end
        foreach (resp[i]) begin
            repeat ($urandom_range(0, 2)) tick();
            myvalid_o = 1'b1;
            mydata_o  = resp[i];
            tick();
            myvalid_o = 1'b0;
        end
        repeat ($urandom_range(0, 2)) tick();
        Done_Sig = 1'b1;
        @(negedge clock25M);
        Done_Sig = 1'b0;
        check({tag, " req_drop"}, cmd_type[3], 1'b0);
        check({tag, " stable"}, stable_err, 0);
    endtask

    task automatic run_test(input string tag);
        logic [7:0] exp_ops[$];
        int         exp_err;
        bit         exp_to;
        int         k;
        int         low_cnt;
        int         idle_budget;
        bit         fin;
        bit         aborted;
        logic [7:0] op;

        // Reference model: command stream and results from the scenario.
        exp_ops = {8'h90, 8'h06, 8'h20};
        exp_to  = 1'b0;
        exp_err = 0;
        if (busy_n[0] >= TB_POLL_MAX) begin
            repeat (TB_POLL_MAX) exp_ops.push_back(8'h05);
            exp_ops.push_back(8'h04);
            exp_to = 1'b1;
        end else begin
            repeat (busy_n[0] + 1) exp_ops.push_back(8'h05);
            exp_ops.push_back(8'h06);
            exp_ops.push_back(8'h02);
            if (busy_n[1] >= TB_POLL_MAX) begin
                repeat (TB_POLL_MAX) exp_ops.push_back(8'h05);
                exp_ops.push_back(8'h04);
                exp_to = 1'b1;
            end else begin
                repeat (busy_n[1] + 1) exp_ops.push_back(8'h05);
                exp_ops.push_back(8'h03);
                for (int i = 0; i < 256; i++)
                    if (i >= rd_len || rd_data[i] != 8'(i)) exp_err++;
            end
        end

        poll_phase = 0;
        poll_idx   = 0;

        @(negedge clock25M);
        start = 1'b1;
        @(negedge clock25M);
        start = 1'b0;
        check({tag, " busy_after_start"}, busy, 1'b1);
        check({tag, " cleared_on_start"}, {err_cnt, test_pass, timeout, mfr_id, dev_id}, 0);
        check({tag, " req_lat1"}, cmd_type[3], 1'b0);
        @(negedge clock25M);
        check({tag, " req_lat2"}, cmd_type[3], 1'b1);

        k           = 0;
        low_cnt     = 2;
        idle_budget = 0;
        fin         = 1'b0;
        aborted     = 1'b0;
        while (!fin && idle_budget < 4000) begin
            if (test_done) begin
                fin = 1'b1;
            end else if (cmd_type[3]) begin
                op = flash_cmd;
                check({tag, $sformatf(" gap%0d", k)}, low_cnt >= 2, 1'b1);
                check({tag, $sformatf(" op%0d", k)}, op, (k < exp_ops.size()) ? exp_ops[k] : 8'h00);
                check({tag, $sformatf(" code%0d", k)}, cmd_type[2:0], exp_code(op));
                check({tag, $sformatf(" addr%0d", k)}, flash_addr, exp_addr(op));
                k++;
                if (reset_in_pp && op == 8'h02) begin
                    #5 flash_rst = 1'b1;
                    #1;
                    check({tag, " rst_outputs"},
                          {cmd_type, flash_cmd, flash_addr, busy, test_done, test_pass,
                           err_cnt, timeout, mfr_id, dev_id, seq_state}, 80'd0);
                    @(negedge clock25M);
                    @(negedge clock25M);
                    flash_rst = 1'b0;
                    @(negedge clock25M);
                    check({tag, " idle_after_rst"}, {busy, cmd_type, seq_state}, 0);
                    aborted = 1'b1;
                    fin     = 1'b1;
                end else begin
                    serve_cmd({tag, $sformatf(" c%0d", k)}, op);
                    low_cnt = 0;
                    if ($urandom_range(0, 3) == 0) begin
                        // Done_Sig with nothing outstanding must be ignored.
                        low_cnt++;
                        Done_Sig = 1'b1;
                        @(negedge clock25M);
                        Done_Sig = 1'b0;
                    end
                end
            end else begin
                low_cnt++;
                idle_budget++;
                @(negedge clock25M);
            end
        end

        if (!aborted) begin
            check({tag, " finished"}, fin, 1'b1);
            check({tag, " n_ops"}, k, exp_ops.size());
            check({tag, " err_cnt"}, err_cnt, exp_err);
            check({tag, " timeout"}, timeout, exp_to);
            check({tag, " pass"}, test_pass, (exp_err == 0) && !exp_to);
            check({tag, " ids"}, {mfr_id, dev_id}, {id_q[3], id_q[4]});
            @(negedge clock25M);
            check({tag, " done_pulse"}, {test_done, busy}, 2'b00);
            check({tag, " pass_sticky"}, test_pass, (exp_err == 0) && !exp_to);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: time %0t exceeded", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        set_defaults();
        #1 flash_rst = 1'b1;
        repeat (3) @(negedge clock25M);
        check("reset_outputs",
              {cmd_type, flash_cmd, flash_addr, busy, test_done, test_pass,
               err_cnt, timeout, mfr_id, dev_id, seq_state}, 80'd0);
        flash_rst = 1'b0;
        @(negedge clock25M);

        Done_Sig = 1'b1;
        @(negedge clock25M);
        Done_Sig  = 1'b0;
        myvalid_o = 1'b1;
        mydata_o  = 8'hA5;
        @(negedge clock25M);
        myvalid_o = 1'b0;
        repeat (2) @(negedge clock25M);
        check("idle_ignore", {cmd_type, busy, seq_state, err_cnt, mfr_id, dev_id}, 0);

        set_defaults();
        start_while_busy = 1'b1;
        run_test("nominal");

        set_defaults();
        rd_data[17]  = 8'h00;
        rd_data[200] = 8'hFF;
        run_test("two_bad");

        set_defaults();
        rd_len = 250;
        run_test("short_read");

        set_defaults();
        busy_n[0] = STUCK;
        run_test("stuck_poll1");

        set_defaults();
        busy_n[1] = STUCK;
        run_test("stuck_poll2");

        for (int t = 0; t < 6; t++) begin
            randomize_scenario();
            run_test($sformatf("rand%0d", t));
        end

        set_defaults();
        reset_in_pp = 1'b1;
        run_test("reset_pp");

        set_defaults();
        busy_n = '{0, 0};
        run_test("after_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
